framebuffer_write_responder: RTL and testbench
==============================================

FRAMEBUFFER_WRITE_RESPONDER -- requirements
Module: framebuffer_write_responder

Interface
REQ-001 SHALL have parameter H_RES, default 640, horizontal resolution in pixels.
REQ-002 SHALL have parameter V_RES, default 480, vertical resolution in pixels.
REQ-003 SHALL have parameter PXL_W, default 12, pixel value width in bits.
REQ-004 SHALL have parameter DEPTH, default 4, write queue depth (power of two, >=2).
REQ-005 SHALL have parameter ADDR_W, default 19, framebuffer word address width (2^ADDR_W >= H_RES*V_RES).
REQ-006 clk  input  1  single clock; all logic on rising edge.
REQ-007 reset  input  1  synchronous, active-high reset.
REQ-008 fb_wr_pxl_x  input  16  pixel column from core.
REQ-009 fb_wr_pxl_y  input  16  pixel row from core.
REQ-010 fb_wr_pxl_value  input  PXL_W  pixel value from core.
REQ-011 fb_wr_en  input  1  core requests a pixel write this cycle.
REQ-012 fb_wr_ready  output  1  responder can accept a request this cycle.
REQ-013 mem_addr  output  ADDR_W  framebuffer memory write address.
REQ-014 mem_wr_data  output  PXL_W  framebuffer memory write data.
REQ-015 mem_wr_en  output  1  write request to framebuffer memory port.
REQ-016 mem_wr_grant  input  1  memory port accepts the write this cycle (scanout has priority).
REQ-017 dropped_count  output  16  count of out-of-bounds requests discarded.
REQ-018 busy  output  1  any accepted write not yet granted.

Function
REQ-019 A request SHALL be accepted in a cycle where fb_wr_en=1 and fb_wr_ready=1; fb_wr_en with fb_wr_ready=0 SHALL have no effect (core must hold request).
REQ-020 Accepted request with x>=H_RES or y>=V_RES SHALL be discarded and increment dropped_count by 1, saturating at 0xFFFF.
REQ-021 In-bounds accepted request SHALL load a stage register with addr=y*H_RES+x (truncated to ADDR_W) and value, valid on the next cycle.
REQ-022 A valid stage entry SHALL be written into the FIFO on the following edge unconditionally; stage never stalls.
REQ-023 fb_wr_ready SHALL equal (fifo_count + stage_valid) < DEPTH, combinational from registered state only (no path from fb_wr_en).
REQ-024 mem_wr_en SHALL be 1 whenever FIFO non-empty; mem_addr/mem_wr_data SHALL present the FIFO head and remain stable until granted.
REQ-025 Head SHALL pop on an edge where mem_wr_en=1 and mem_wr_grant=1; mem_wr_grant while mem_wr_en=0 SHALL be ignored.
REQ-026 Simultaneous push and pop SHALL leave fifo_count unchanged; pointers SHALL wrap modulo DEPTH.
REQ-027 Writes SHALL reach memory in acceptance order; no write merging or reordering.
REQ-028 Latency: request accepted in cycle N with continuous grant SHALL appear as mem_wr_en in cycle N+2 and pop at end of N+2; sustained throughput 1 write/cycle.
REQ-029 busy SHALL equal stage_valid OR fifo_count!=0.

Reset
REQ-030 On reset=1 at an edge: FIFO pointers/count=0, stage_valid=0, dropped_count=0; pending writes discarded.
REQ-031 Outputs after reset: fb_wr_ready=1, mem_wr_en=0, busy=0, mem_addr=0, mem_wr_data=0, dropped_count=0.
REQ-032 Request presented in the same cycle as reset=1 SHALL NOT be accepted.

Verification
REQ-033 Single write: x=3, y=2, value=0xABC, grant held 1 -> mem_wr_en in cycle N+2 with mem_addr=1283, mem_wr_data=0xABC, busy low at N+3.
REQ-034 Backpressure: grant held 0, issue 5 writes with fb_wr_en held -> 4 accepted, fb_wr_ready=0 thereafter, mem_addr stable at first entry; raise grant -> 4 writes in order, then 5th accepted.
REQ-035 Bounds: x=640,y=0 then x=0,y=480 then x=639,y=479 -> dropped_count=2, single memory write at addr 307199.
REQ-036 Saturation: 65537 out-of-bounds requests -> dropped_count=0xFFFF, no mem_wr_en ever.
REQ-037 Streaming: 16 back-to-back writes with grant toggling 1,0 each cycle -> all 16 written in order, no loss, count never exceeds DEPTH.
REQ-038 Reset mid-operation: 3 writes queued with grant 0, assert reset one cycle -> mem_wr_en=0, busy=0, fb_wr_ready=1 next cycle; queued writes never emitted.

Source files
------------

// File: rtl/framebuffer_write_responder.sv
// ---------------------------------------------------------------------------
// framebuffer_write_responder
//
// Accepts pixel write requests (x, y, value) from a drawing core, discards
// requests that fall outside the visible raster, converts in-bounds requests
// to a linear framebuffer word address and queues them towards a shared
// memory write port. The memory port may refuse a write in any cycle
// (scanout has priority), so the queue absorbs those stalls and pushes
// backpressure to the core through fb_wr_ready.
//
// Datapath:
//   core request -> [bounds check + address calc] -> stage register
//                -> DEPTH-entry FIFO -> memory write port
//
// Handshakes (both sides):
//   Core side  : a request transfers on a rising edge where fb_wr_en=1 and
//                fb_wr_ready=1. fb_wr_ready depends on registered state only,
//                so the core may legally compute fb_wr_en from it. While
//                fb_wr_ready=0 the core holds its request unchanged.
//   Memory side: mem_wr_en=1 presents the FIFO head on mem_addr/mem_wr_data;
//                the write transfers on an edge where mem_wr_grant=1. The
//                presented word stays stable until granted. A grant while
//                mem_wr_en=0 is ignored.
//
// Ports:
//   clk, reset           single rising-edge clock, synchronous active-high reset
//   fb_wr_pxl_x/_y       pixel column/row (16 bit)
//   fb_wr_pxl_value      pixel value (PXL_W bits)
//   fb_wr_en             core request strobe
//   fb_wr_ready          responder can accept a request this cycle
//   mem_addr             framebuffer word address of the FIFO head
//   mem_wr_data          pixel value of the FIFO head
//   mem_wr_en            FIFO head is valid and requests the memory port
//   mem_wr_grant         memory port takes the head this cycle
//   dropped_count        saturating count of out-of-bounds requests discarded
//   busy                 some accepted write has not yet been granted
// ---------------------------------------------------------------------------
module framebuffer_write_responder #(
    parameter int H_RES  = 640,
    parameter int V_RES  = 480,
    parameter int PXL_W  = 12,
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 19
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [15:0]       fb_wr_pxl_x,
    input  logic [15:0]       fb_wr_pxl_y,
    input  logic [PXL_W-1:0]  fb_wr_pxl_value,
    input  logic              fb_wr_en,
    output logic              fb_wr_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [PXL_W-1:0]  mem_wr_data,
    output logic              mem_wr_en,
    input  logic              mem_wr_grant,
    output logic [15:0]       dropped_count,
    output logic              busy
);

    // Pointer width indexes DEPTH entries; the count needs one more bit so
    // that a completely full FIFO (count == DEPTH) is representable.
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    logic              stage_valid_q, stage_valid_d;
    logic [ADDR_W-1:0] stage_addr_q,  stage_addr_d;
    logic [PXL_W-1:0]  stage_data_q,  stage_data_d;

    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q,  count_d;

    logic [15:0]       dropped_q, dropped_d;

    // FIFO storage is not reset: an entry is only ever observed while the
    // count says it is valid, and the head outputs are gated to zero when
    // the FIFO is empty.
    logic [ADDR_W-1:0] fifo_addr_q [DEPTH];
    logic [PXL_W-1:0]  fifo_data_q [DEPTH];

    // -----------------------------------------------------------------------
    // Request side
    // -----------------------------------------------------------------------
    logic              in_bounds;
    logic              accept;
    logic [ADDR_W-1:0] req_addr;
    logic [CNT_W:0]    occupancy;

    // Entries in flight = FIFO contents plus the stage register. The stage
    // always drains into the FIFO on the next edge, so it must be counted
    // against FIFO space before a new request is taken.
    assign occupancy   = {1'b0, count_q} + {{CNT_W{1'b0}}, stage_valid_q};
    assign fb_wr_ready = (occupancy < (CNT_W+1)'(DEPTH));

    // A request in a reset cycle is never accepted; reset also wins inside
    // the sequential block, this keeps the intent explicit at the source.
    assign accept = fb_wr_en & fb_wr_ready & ~reset;

    assign in_bounds = (32'(fb_wr_pxl_x) < 32'(H_RES)) &&
                       (32'(fb_wr_pxl_y) < 32'(V_RES));

    // Linear address y*H_RES + x, computed directly at ADDR_W bits so the
    // result is the full product truncated modulo 2^ADDR_W.
    assign req_addr = ADDR_W'(fb_wr_pxl_y) * ADDR_W'(H_RES) + ADDR_W'(fb_wr_pxl_x);

    // -----------------------------------------------------------------------
    // FIFO control
    // -----------------------------------------------------------------------
    logic fifo_nonempty;
    logic push;
    logic pop;

    assign fifo_nonempty = (count_q != '0);
    // The stage never stalls: a valid stage entry always enters the FIFO.
    // The ready rule above guarantees there is room for it.
    assign push = stage_valid_q;
    assign pop  = fifo_nonempty & mem_wr_grant;

    always_comb begin
        stage_valid_d = 1'b0;
        stage_addr_d  = stage_addr_q;
        stage_data_d  = stage_data_q;
        dropped_d     = dropped_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        count_d       = count_q;

        if (accept) begin
            if (in_bounds) begin
                stage_valid_d = 1'b1;
                stage_addr_d  = req_addr;
                stage_data_d  = fb_wr_pxl_value;
            end else if (dropped_q != 16'hFFFF) begin
                dropped_d = dropped_q + 16'd1;
            end
        end

        // Pointers are PTR_W bits wide and DEPTH is a power of two, so the
        // natural binary wrap is the modulo-DEPTH wrap.
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end

        // Simultaneous push and pop leaves the count unchanged.
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            stage_valid_q <= 1'b0;
            stage_addr_q  <= '0;
            stage_data_q  <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            dropped_q     <= '0;
        end else begin
            stage_valid_q <= stage_valid_d;
            stage_addr_q  <= stage_addr_d;
            stage_data_q  <= stage_data_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            dropped_q     <= dropped_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && push) begin
            fifo_addr_q[wr_ptr_q] <= stage_addr_q;
            fifo_data_q[wr_ptr_q] <= stage_data_q;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign mem_wr_en     = fifo_nonempty;
    assign mem_addr      = fifo_nonempty ? fifo_addr_q[rd_ptr_q] : '0;
    assign mem_wr_data   = fifo_nonempty ? fifo_data_q[rd_ptr_q] : '0;
    assign dropped_count = dropped_q;
    assign busy          = stage_valid_q | fifo_nonempty;

endmodule

// File: tb/tb_framebuffer_write_responder.sv
`timescale 1ns/1ps
module tb_framebuffer_write_responder;

  localparam int H_RES  = 640;
  localparam int V_RES  = 480;
  localparam int PXL_W  = 12;
  localparam int DEPTH  = 4;
  localparam int ADDR_W = 19;
  localparam int W      = ADDR_W + PXL_W;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset;
  logic [15:0]       fb_wr_pxl_x;
  logic [15:0]       fb_wr_pxl_y;
  logic [PXL_W-1:0]  fb_wr_pxl_value;
  logic              fb_wr_en;
  logic              fb_wr_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic [PXL_W-1:0]  mem_wr_data;
  logic              mem_wr_en;
  logic              mem_wr_grant;
  logic [15:0]       dropped_count;
  logic              busy;

  framebuffer_write_responder #(
    .H_RES(H_RES), .V_RES(V_RES), .PXL_W(PXL_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)
  ) dut (
    .clk(clk),
    .reset(reset),
    .fb_wr_pxl_x(fb_wr_pxl_x),
    .fb_wr_pxl_y(fb_wr_pxl_y),
    .fb_wr_pxl_value(fb_wr_pxl_value),
    .fb_wr_en(fb_wr_en),
    .fb_wr_ready(fb_wr_ready),
    .mem_addr(mem_addr),
    .mem_wr_data(mem_wr_data),
    .mem_wr_en(mem_wr_en),
    .mem_wr_grant(mem_wr_grant),
    .dropped_count(dropped_count),
    .busy(busy)
  );

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];
  int           checks = 0;
  int           errors = 0;
  int           drop_model = 0;
  int           mem_en_seen = 0;
  logic         grant_toggle = 1'b0;
  logic         prev_stall = 1'b0;
  logic [W-1:0] stall_word = '0;

  typedef struct {
    int               x;
    int               y;
    logic [PXL_W-1:0] v;
    logic             exp_acc;
    logic [ADDR_W-1:0] exp_addr;
  } vec_t;
  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // Called at the falling edge: a granted head will pop on the next rising edge.
  task automatic sb_sample();
    logic [W-1:0] got;
    logic [W-1:0] want;
    if (reset) begin
      prev_stall = 1'b0;
      return;
    end
    got = {mem_addr, mem_wr_data};
    if (mem_wr_en) mem_en_seen++;
    if (prev_stall) begin
      chk("stall_en_held", 32'(mem_wr_en), 32'd1);
      chk("stall_word_stable", 32'(got), 32'(stall_word));
    end
    prev_stall = mem_wr_en && !mem_wr_grant;
    stall_word = got;
    if (mem_wr_en && mem_wr_grant) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected_write actual_addr=%0d actual_data=0x%0h expected=none",
                 mem_addr, mem_wr_data);
      end else begin
        want = exp_q.pop_front();
        chk("sb_addr", 32'(mem_addr), 32'(want[W-1:PXL_W]));
        chk("sb_data", 32'(mem_wr_data), 32'(want[PXL_W-1:0]));
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    sb_sample();
    @(posedge clk);
    #1;
    if (grant_toggle) mem_wr_grant = ~mem_wr_grant;
  endtask

  // Independent model of what an accepted request should do.
  task automatic model_accept(input int x, input int y, input logic [PXL_W-1:0] v);
    logic [ADDR_W-1:0] a;
    if (x < H_RES && y < V_RES) begin
      a = ADDR_W'(y * H_RES + x);
      exp_q.push_back({a, v});
      chk("occupancy_le_depth", 32'(exp_q.size() <= DEPTH), 32'd1);
    end else if (drop_model < 65535) begin
      drop_model++;
    end
  endtask

  task automatic send(input int x, input int y, input logic [PXL_W-1:0] v);
    int waited;
    waited = 0;
    fb_wr_pxl_x = 16'(x);
    fb_wr_pxl_y = 16'(y);
    fb_wr_pxl_value = v;
    fb_wr_en = 1'b1;
    while (!fb_wr_ready && waited < 200) begin
      step();
      waited++;
    end
    if (!fb_wr_ready) begin
      chk("send_ready_timeout", 32'(fb_wr_ready), 32'd1);
      fb_wr_en = 1'b0;
      return;
    end
    model_accept(x, y, v);
    step();
    fb_wr_en = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    grant_toggle = 1'b0;
    mem_wr_grant = 1'b1;
    while ((busy || exp_q.size() != 0) && n < 100) begin
      step();
      n++;
    end
    chk("drain_queue_empty", 32'(exp_q.size()), 32'd0);
    chk("drain_busy_low", 32'(busy), 32'd0);
  endtask

  task automatic do_reset(input logic req_during_reset);
    reset = 1'b1;
    fb_wr_en = req_during_reset;
    fb_wr_pxl_x = 16'd1;
    fb_wr_pxl_y = 16'd1;
    fb_wr_pxl_value = 12'h5A5;
    step();
    reset = 1'b0;
    fb_wr_en = 1'b0;
    exp_q.delete();
    drop_model = 0;
    prev_stall = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_ready"},   32'(fb_wr_ready), 32'd1);
    chk({tag, "_mem_en"},  32'(mem_wr_en), 32'd0);
    chk({tag, "_busy"},    32'(busy), 32'd0);
    chk({tag, "_addr"},    32'(mem_addr), 32'd0);
    chk({tag, "_data"},    32'(mem_wr_data), 32'd0);
    chk({tag, "_dropped"}, 32'(dropped_count), 32'd0);
  endtask

  // Single request with continuous grant, checking exact latency.
  task automatic do_vec(input vec_t t);
    fb_wr_pxl_x = 16'(t.x);
    fb_wr_pxl_y = 16'(t.y);
    fb_wr_pxl_value = t.v;
    fb_wr_en = 1'b1;
    chk("vec_ready", 32'(fb_wr_ready), 32'd1);
    model_accept(t.x, t.y, t.v);
    step();                                   // cycle N+1
    fb_wr_en = 1'b0;
    chk("vec_n1_mem_en", 32'(mem_wr_en), 32'd0);
    chk("vec_n1_busy", 32'(busy), 32'(t.exp_acc));
    chk("vec_dropped", 32'(dropped_count), 32'(drop_model));
    step();                                   // cycle N+2
    chk("vec_n2_mem_en", 32'(mem_wr_en), 32'(t.exp_acc));
    if (t.exp_acc) begin
      chk("vec_n2_addr", 32'(mem_addr), 32'(t.exp_addr));
      chk("vec_n2_data", 32'(mem_wr_data), 32'(t.v));
    end
    step();                                   // cycle N+3
    chk("vec_n3_busy", 32'(busy), 32'd0);
    chk("vec_n3_mem_en", 32'(mem_wr_en), 32'd0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2_000_000;
    $display("FAIL watchdog_timeout actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  // ---------------- main test ----------------
  initial begin
    vecs[0] = '{x: 3,     y: 2,     v: 12'hABC, exp_acc: 1'b1, exp_addr: 19'd1283};
    vecs[1] = '{x: 640,   y: 0,     v: 12'h111, exp_acc: 1'b0, exp_addr: 19'd0};
    vecs[2] = '{x: 0,     y: 480,   v: 12'h222, exp_acc: 1'b0, exp_addr: 19'd0};
    vecs[3] = '{x: 639,   y: 479,   v: 12'h333, exp_acc: 1'b1, exp_addr: 19'd307199};
    vecs[4] = '{x: 639,   y: 0,     v: 12'h444, exp_acc: 1'b1, exp_addr: 19'd639};
    vecs[5] = '{x: 0,     y: 1,     v: 12'h555, exp_acc: 1'b1, exp_addr: 19'd640};
    vecs[6] = '{x: 100,   y: 200,   v: 12'hFFF, exp_acc: 1'b1, exp_addr: 19'd128100};
    vecs[7] = '{x: 65535, y: 65535, v: 12'h000, exp_acc: 1'b0, exp_addr: 19'd0};

    reset = 1'b1;
    fb_wr_en = 1'b0;
    fb_wr_pxl_x = '0;
    fb_wr_pxl_y = '0;
    fb_wr_pxl_value = '0;
    mem_wr_grant = 1'b0;
    step();
    do_reset(1'b0);
    check_idle("reset");

    // Table: single writes, bounds, latency.
    mem_wr_grant = 1'b1;
    for (int i = 0; i < 8; i++) begin
      do_vec(vecs[i]);
      if (i == 3) chk("bounds_dropped_two", 32'(dropped_count), 32'd2);
    end
    chk("table_dropped_total", 32'(dropped_count), 32'd3);

    // Backpressure: four fill the queue, fifth waits until grant returns.
    do_reset(1'b0);
    mem_wr_grant = 1'b0;
    for (int i = 0; i < 4; i++) send(10 + i, 20, 12'(16'h100 + i));
    chk("bp_ready_low", 32'(fb_wr_ready), 32'd0);
    fb_wr_pxl_x = 16'd14;
    fb_wr_pxl_y = 16'd20;
    fb_wr_pxl_value = 12'h104;
    fb_wr_en = 1'b1;
    for (int i = 0; i < 3; i++) step();
    chk("bp_ready_still_low", 32'(fb_wr_ready), 32'd0);
    chk("bp_mem_en", 32'(mem_wr_en), 32'd1);
    chk("bp_head_addr", 32'(mem_addr), 32'(20 * H_RES + 10));
    chk("bp_head_data", 32'(mem_wr_data), 32'h100);
    chk("bp_queued", 32'(exp_q.size()), 32'd4);
    mem_wr_grant = 1'b1;
    send(14, 20, 12'h104);
    drain();

    // Streaming with grant toggling every cycle.
    mem_wr_grant = 1'b1;
    grant_toggle = 1'b1;
    for (int i = 0; i < 16; i++)
      send((i * 37) % H_RES, (i * 29) % V_RES, 12'($urandom_range(0, 4095)));
    drain();

    // Reset mid-operation, with a request held during the reset cycle.
    mem_wr_grant = 1'b0;
    for (int i = 0; i < 3; i++) send(i, 5, 12'(16'h200 + i));
    step();
    chk("midrst_busy_before", 32'(busy), 32'd1);
    do_reset(1'b1);
    check_idle("midrst");
    mem_en_seen = 0;
    mem_wr_grant = 1'b1;
    for (int i = 0; i < 6; i++) step();
    chk("midrst_no_writes", 32'(mem_en_seen), 32'd0);
    chk("midrst_busy_after", 32'(busy), 32'd0);

    // Saturation of the drop counter.
    do_reset(1'b0);
    mem_en_seen = 0;
    for (int i = 0; i < 65537; i++) begin
      if (i[0]) send(H_RES + (i % 100), 0, 12'h0);
      else      send(i % H_RES, V_RES + (i % 7), 12'h0);
      if (i == 65533) chk("sat_below_max", 32'(dropped_count), 32'hFFFE);
    end
    step();
    chk("sat_dropped_max", 32'(dropped_count), 32'hFFFF);
    chk("sat_dropped_model", 32'(dropped_count), 32'(drop_model));
    chk("sat_no_mem_en", 32'(mem_en_seen), 32'd0);
    chk("sat_busy", 32'(busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
